// File: rtl/uart_stream_thread_if.sv
// uart_stream_thread_if: imem fetch, bmem read and shared UART writer signals of one stream thread
//   imem_addr/imem_data              instruction fetch, combinational data
//   bmem_addr/bmem_rd_en/bmem_data   word read, data one cycle after the strobe
//   write_lock_req/write_lock_res    UART lock request and grant
//   write_data/write_data_valid/write_ready  byte stream, transfer on valid & ready
interface uart_stream_thread_if #(parameter int BITWIDTH = 32);
  logic [BITWIDTH-1:0] imem_addr;
  logic [BITWIDTH-1:0] imem_data;
  logic [BITWIDTH-1:0] bmem_addr;
  logic                bmem_rd_en;
  logic [BITWIDTH-1:0] bmem_data;
  logic                write_lock_req;
  logic                write_lock_res;
  logic                write_ready;
  logic [7:0]          write_data;
  logic                write_data_valid;
  modport master (
    output imem_addr, bmem_addr, bmem_rd_en, write_lock_req, write_data, write_data_valid,
    input  imem_data, bmem_data, write_lock_res, write_ready
  );
  modport slave (
    input  imem_addr, bmem_addr, bmem_rd_en, write_lock_req, write_data, write_data_valid,
    output imem_data, bmem_data, write_lock_res, write_ready
  );
endinterface

// File: rtl/uart_stream_thread.sv
// uart_stream_thread: instruction-driven thread streaming bmem words as packets to a shared UART writer
//   clock, reset (async, active-low), running (start on rise, stop between instructions)
//   idle (in DONE), error (sticky illegal WRITE count), bus (master side of uart_stream_thread_if)
module uart_stream_thread #(
  parameter int BITWIDTH    = 32,
  parameter int MAX_WORDS   = 256,
  parameter int COUNT_BYTES = 4,
  parameter int PC_STEP     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic running,
  output logic idle,
  output logic error,
  uart_stream_thread_if.master bus
);
  localparam int WB  = BITWIDTH / 8;
  localparam int CW  = COUNT_BYTES * 8;
  localparam int BIW = $clog2(WB) + 1;
  typedef enum logic [2:0] {DONE, FETCH, LOCK, COUNT, HEADER, DATA, RELEASE} state_t;
  state_t state;
  logic [BITWIDTH-1:0] pc, baddr, buf_w, sh;
  logic [CW-1:0] cnt_sh;
  logic [8:0] n;
  logic [7:0] hdr, wdata;
  logic [9:0] widx, widx_nx;
  logic [BIW-1:0] bi;
  logic rd_en, got, lock_req, valid, running_q, xfer;
  logic [26:0] ins;
  logic unused_hi;
  assign ins       = bus.imem_data[26:0];
  assign unused_hi = ^bus.imem_data[BITWIDTH-1:27];
  assign xfer      = valid && bus.write_ready;
  assign widx_nx   = widx + 10'd1;
  assign bus.imem_addr        = pc;
  assign bus.bmem_addr        = baddr;
  assign bus.bmem_rd_en       = rd_en;
  assign bus.write_lock_req   = lock_req;
  assign bus.write_data       = wdata;
  assign bus.write_data_valid = valid;
  // buf_w holds the prefetched next word; sh shifts out the word being sent
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= DONE;
      pc        <= '0;
      idle      <= 1'b1;
      error     <= 1'b0;
      baddr     <= '0;
      buf_w     <= '0;
      sh        <= '0;
      cnt_sh    <= '0;
      n         <= '0;
      hdr       <= '0;
      wdata     <= '0;
      widx      <= '0;
      bi        <= '0;
      rd_en     <= 1'b0;
      got       <= 1'b0;
      lock_req  <= 1'b0;
      valid     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      running_q <= running;
      rd_en     <= 1'b0;
      got       <= rd_en;
      if (got) buf_w <= bus.bmem_data;
      case (state)
        DONE: if (running && !running_q) begin
          state <= FETCH;
          pc    <= '0;
          idle  <= 1'b0;
        end
        FETCH:
          if (!running || ins[1:0] == 2'b00) begin
            state <= DONE;
            idle  <= 1'b1;
          end else if (ins[1:0] == 2'b10) pc <= BITWIDTH'({ins[9:2], 2'b00});
          else if (ins[1:0] == 2'b11) pc <= pc + BITWIDTH'(PC_STEP);
          else if (32'(ins[26:18]) > MAX_WORDS) begin
            error <= 1'b1;
            state <= DONE;
            idle  <= 1'b1;
          end else begin
            n        <= ins[26:18];
            hdr      <= ins[17:10];
            baddr    <= BITWIDTH'({ins[9:2], 8'h00});
            rd_en    <= ins[26:18] != 9'd0;
            cnt_sh   <= CW'(BITWIDTH'(ins[26:18]) * BITWIDTH'(WB) + BITWIDTH'(1));
            widx     <= '0;
            lock_req <= 1'b1;
            state    <= LOCK;
          end
        LOCK: if (bus.write_lock_res) begin
          state  <= COUNT;
          valid  <= 1'b1;
          wdata  <= cnt_sh[7:0];
          cnt_sh <= cnt_sh >> 8;
          bi     <= '0;
        end
        COUNT: if (xfer) begin
          if (bi == BIW'(COUNT_BYTES - 1)) begin
            state <= HEADER;
            wdata <= hdr;
          end else begin
            wdata  <= cnt_sh[7:0];
            cnt_sh <= cnt_sh >> 8;
            bi     <= bi + 1'b1;
          end
        end
        HEADER: if (xfer) begin
          if (n == 9'd0) begin
            state    <= RELEASE;
            valid    <= 1'b0;
            lock_req <= 1'b0;
          end else begin
            state <= DATA;
            wdata <= buf_w[7:0];
            sh    <= buf_w >> 8;
            bi    <= '0;
            if (n > 9'd1) begin
              rd_en <= 1'b1;
              baddr <= baddr + BITWIDTH'(1);
            end
          end
        end
        DATA: if (xfer) begin
          if (bi != BIW'(WB - 1)) begin
            wdata <= sh[7:0];
            sh    <= sh >> 8;
            bi    <= bi + 1'b1;
          end else if (widx_nx == {1'b0, n}) begin
            state    <= RELEASE;
            valid    <= 1'b0;
            lock_req <= 1'b0;
          end else begin
            widx  <= widx_nx;
            wdata <= buf_w[7:0];
            sh    <= buf_w >> 8;
            bi    <= '0;
            if (widx + 10'd2 < {1'b0, n}) begin
              rd_en <= 1'b1;
              baddr <= baddr + BITWIDTH'(1);
            end
          end
        end
        RELEASE: if (!bus.write_lock_res) begin
          pc    <= pc + BITWIDTH'(PC_STEP);
          state <= FETCH;
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_stream_thread.sv
// tb_uart_stream_thread: table-driven WRITE vectors and corner sequences with a byte scoreboard
module tb_uart_stream_thread;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic running = 1'b0;
  logic idle, error;
  uart_stream_thread_if #(.BITWIDTH(32)) bus();
  uart_stream_thread #(.BITWIDTH(32), .MAX_WORDS(256), .COUNT_BYTES(4), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .running(running), .idle(idle), .error(error), .bus(bus.master)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [7:0] base, hdr;
    int n;
    logic [4:0] hi;
    bit toggle;
    int gdel, rdel;
    logic [31:0] exp_count, exp_pc;
    logic exp_err;
    int exp_rd;
  } vec_t;
  vec_t vt[7];
  logic [31:0] imem [0:63];
  logic [31:0] bmem_q = '0;
  logic [7:0] byte_q[$];
  int applied = 0, miscompares = 0, rd_cnt = 0, xfer_cnt = 0, grant_delay = 0, rel_delay = 0;
  bit ready_mode = 0, any_req = 0, stall_pend = 0, was_rel = 0;
  logic [7:0] stall_data;
  logic [31:0] prev_addr = '0;
  assign bus.imem_data = imem[bus.imem_addr[7:2]];
  assign bus.bmem_data = bmem_q;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h11223344;
    if (a == 32'h101) return 32'h55667788;
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction
  always @(posedge clock) if (bus.bmem_rd_en) bmem_q <= mem_word(bus.bmem_addr);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    bus.write_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 bus.write_ready = ready_mode ? ~bus.write_ready : 1'b1;
    end
  end
  initial begin
    int gcnt = 0, rcnt = 0;
    bus.write_lock_res = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.write_lock_req) begin
        rcnt = 0;
        if (!bus.write_lock_res) begin
          if (gcnt >= grant_delay) bus.write_lock_res = 1'b1;
          else gcnt++;
        end
      end else begin
        gcnt = 0;
        if (bus.write_lock_res) begin
          if (rcnt >= rel_delay) bus.write_lock_res = 1'b0;
          else rcnt++;
        end
      end
    end
  end
  always @(negedge clock) begin
    if (bus.bmem_rd_en) rd_cnt++;
    if (bus.write_lock_req) any_req = 1;
    if (was_rel) check("release_waits_grant_drop", bus.imem_addr, prev_addr);
    was_rel = reset && !bus.write_lock_req && bus.write_lock_res && !idle;
    prev_addr = bus.imem_addr;
    if (stall_pend) begin
      check("stall_valid_held", 32'(bus.write_data_valid), 1);
      check("stall_data_held", 32'(bus.write_data), 32'(stall_data));
      stall_pend = 0;
    end
    if (bus.write_data_valid) begin
      check("valid_only_with_grant", 32'(bus.write_lock_res), 1);
      if (bus.write_ready) begin
        xfer_cnt++;
        if (byte_q.size() == 0) check("unexpected_byte", 32'(bus.write_data), 32'hFFFF_FFFF);
        else check("byte", 32'(bus.write_data), 32'(byte_q.pop_front()));
      end else begin
        stall_pend = 1;
        stall_data = bus.write_data;
      end
    end
  end
  task automatic push_write(input logic [7:0] base, input logic [7:0] hdr, input int n, input logic [31:0] cnt);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) byte_q.push_back(cnt[8*i +: 8]);
    byte_q.push_back(hdr);
    for (int k = 0; k < n; k++) begin
      w = mem_word({16'h0, base, 8'h00} + 32'(k));
      for (int i = 0; i < 4; i++) byte_q.push_back(w[8*i +: 8]);
    end
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b0;
    running = 1'b0;
    repeat (3) @(negedge clock);
    check({tag, "_rst_idle"}, 32'(idle), 1);
    check({tag, "_rst_error"}, 32'(error), 0);
    check({tag, "_rst_req"}, 32'(bus.write_lock_req), 0);
    check({tag, "_rst_valid"}, 32'(bus.write_data_valid), 0);
    check({tag, "_rst_rd"}, 32'(bus.bmem_rd_en), 0);
    check({tag, "_rst_pc"}, bus.imem_addr, 0);
    check({tag, "_rst_wdata"}, 32'(bus.write_data), 0);
    for (int i = 0; i < 64; i++) imem[i] = '0;
    byte_q.delete();
    reset = 1'b1;
    rd_cnt = 0;
    any_req = 0;
  endtask
  task automatic run_to_idle(input string tag, input int budget);
    bit busy = 0, done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (!idle) busy = 1;
      else if (busy) done = 1;
    end
    check({tag, "_finished"}, 32'(done), 1);
  endtask
  task automatic wait_bytes(input int target, input int budget);
    for (int i = 0; i < budget && xfer_cnt < target; i++) @(negedge clock);
    check("bytes_reached", 32'(xfer_cnt >= target), 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{8'h01, 8'hA5, 2,   5'h00, 0, 0, 0, 32'h9,   32'h4, 1'b0, 2};
    vt[1] = '{8'h01, 8'hA5, 2,   5'h00, 1, 0, 0, 32'h9,   32'h4, 1'b0, 2};
    vt[2] = '{8'h05, 8'h3C, 0,   5'h00, 0, 0, 0, 32'h1,   32'h4, 1'b0, 0};
    vt[3] = '{8'h02, 8'h5A, 1,   5'h00, 0, 5, 3, 32'h5,   32'h4, 1'b0, 1};
    vt[4] = '{8'h7F, 8'hFF, 3,   5'h1F, 1, 2, 1, 32'hD,   32'h4, 1'b0, 3};
    vt[5] = '{8'h10, 8'h01, 256, 5'h00, 0, 0, 0, 32'h401, 32'h4, 1'b0, 256};
    vt[6] = '{8'h03, 8'h11, 257, 5'h00, 0, 0, 0, 32'h0,   32'h0, 1'b1, 0};
    for (int v = 0; v < 7; v++) begin
      string t;
      t = $sformatf("v%0d", v);
      do_reset(t);
      imem[0] = {vt[v].hi, 9'(vt[v].n), vt[v].hdr, vt[v].base, 2'b01};
      ready_mode = vt[v].toggle;
      grant_delay = vt[v].gdel;
      rel_delay = vt[v].rdel;
      if (!vt[v].exp_err) push_write(vt[v].base, vt[v].hdr, vt[v].n, vt[v].exp_count);
      running = 1'b1;
      run_to_idle(t, 4000);
      running = 1'b0;
      check({t, "_bytes_left"}, byte_q.size(), 0);
      check({t, "_error"}, 32'(error), 32'(vt[v].exp_err));
      check({t, "_pc"}, bus.imem_addr, vt[v].exp_pc);
      check({t, "_rd_pulses"}, rd_cnt, vt[v].exp_rd);
      check({t, "_lock_used"}, 32'(any_req), 32'(!vt[v].exp_err));
      check({t, "_req_dropped"}, 32'(bus.write_lock_req), 0);
    end
    ready_mode = 0;
    grant_delay = 0;
    rel_delay = 0;
    do_reset("prog");
    imem[0] = 32'h0000_0012;
    imem[4] = 32'h0000_0003;
    imem[5] = {5'h0, 9'd300, 8'h22, 8'h01, 2'b01};
    running = 1'b1;
    run_to_idle("prog", 100);
    check("prog_error", 32'(error), 1);
    check("prog_idle", 32'(idle), 1);
    check("prog_pc", bus.imem_addr, 32'h14);
    check("prog_no_lock", 32'(any_req), 0);
    running = 1'b0;
    do_reset("stop");
    imem[0] = {5'h0, 9'd2, 8'hA5, 8'h01, 2'b01};
    imem[1] = 32'h0000_0003;
    push_write(8'h01, 8'hA5, 2, 32'h9);
    running = 1'b1;
    wait_bytes(xfer_cnt + 7, 200);
    running = 1'b0;
    run_to_idle("stop", 200);
    check("stop_bytes_left", byte_q.size(), 0);
    check("stop_pc", bus.imem_addr, 32'h4);
    check("stop_req", 32'(bus.write_lock_req), 0);
    do_reset("arst");
    imem[0] = {5'h0, 9'd4, 8'h77, 8'h03, 2'b01};
    push_write(8'h03, 8'h77, 4, 32'h11);
    running = 1'b1;
    wait_bytes(xfer_cnt + 8, 200);
    #2 reset = 1'b0;
    #1;
    check("arst_req_async", 32'(bus.write_lock_req), 0);
    check("arst_valid_async", 32'(bus.write_data_valid), 0);
    check("arst_idle_async", 32'(idle), 1);
    byte_q.delete();
    running = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 64; i++) imem[i] = '0;
    imem[0] = {5'h0, 9'd1, 8'h42, 8'h01, 2'b01};
    push_write(8'h01, 8'h42, 1, 32'h5);
    reset = 1'b1;
    running = 1'b1;
    @(negedge clock);
    check("restart_pc", bus.imem_addr, 0);
    check("restart_busy", 32'(idle), 0);
    run_to_idle("restart", 200);
    check("restart_bytes_left", byte_q.size(), 0);
    check("restart_pc_end", bus.imem_addr, 32'h4);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
